// File: rtl/ps2_direction_decoder_if.sv
// ps2_direction_decoder_if: keyboard pins in, decoded key levels, pulses and byte stream out
interface ps2_direction_decoder_if;
  logic ps2_clk;
  logic ps2_dat;
  logic [3:0] direction;
  logic start_key;
  logic [4:0] press;
  logic byte_valid;
  logic [7:0] byte_data;
  logic frame_err;
  modport master (input ps2_clk, ps2_dat, output direction, start_key, press, byte_valid, byte_data, frame_err);
  modport slave (output ps2_clk, ps2_dat, input direction, start_key, press, byte_valid, byte_data, frame_err);
endinterface

// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder: PS/2 frame receiver and scan decoder for start plus four arrow keys
module ps2_direction_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT = 50000
) (
  input logic clock,
  input logic reset,
  ps2_direction_decoder_if.master bus
);
  localparam int LW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic clk_s1, clk_s2, dat_s1, dat_s2, armed, fall, good, par, ext, brk, is_final;
  logic bv_n, fe_n, byte_valid, frame_err, start_key;
  logic [LW-1:0] low_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, byte_data;
  logic [3:0] direction;
  logic [4:0] press, hit, held;
  // armed blocks a second accept in the same low phase and any accept straight out of reset
  assign fall = armed && !clk_s2 && low_cnt == LW'(FILTER_LEN - 1);
  assign good = dat_s2 && ^{shreg, par};
  assign is_final = byte_data != 8'hE0 && byte_data != 8'hF0;
  assign held = {start_key, direction};
  assign hit = {!ext && byte_data == 8'h1B, ext && byte_data == 8'h75, ext && byte_data == 8'h72,
                ext && byte_data == 8'h6B, ext && byte_data == 8'h74};
  always_comb begin
    state_n = state;
    bv_n = 1'b0;
    fe_n = 1'b0;
    if (fall)
      case (state)
        IDLE: begin
          state_n = dat_s2 ? IDLE : DATA;
          fe_n = dat_s2;
        end
        DATA: state_n = bit_cnt == 3'd7 ? PARITY : DATA;
        PARITY: state_n = STOP;
        default: begin
          state_n = IDLE;
          bv_n = good;
          fe_n = !good;
        end
      endcase
    else if (state != IDLE && tmo_cnt == TW'(TIMEOUT - 1)) begin
      state_n = IDLE;
      fe_n = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      {clk_s1, clk_s2, dat_s1, dat_s2, armed, par, ext, brk} <= '0;
      {byte_valid, frame_err, start_key} <= '0;
      state <= IDLE;
      low_cnt <= '0;
      tmo_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      byte_data <= '0;
      direction <= '0;
      press <= '0;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= bus.ps2_dat;
      dat_s2 <= dat_s1;
      low_cnt <= clk_s2 ? '0 : low_cnt + LW'(low_cnt != LW'(FILTER_LEN));
      armed <= clk_s2 || (armed && !fall);
      state <= state_n;
      tmo_cnt <= fall ? TW'(1) : state == IDLE ? '0 : tmo_cnt + 1'b1;
      if (fall && state == DATA) shreg <= {dat_s2, shreg[7:1]};
      if (fall) bit_cnt <= state == DATA ? bit_cnt + 1'b1 : '0;
      if (fall && state == PARITY) par <= dat_s2;
      byte_valid <= bv_n;
      frame_err <= fe_n;
      if (bv_n) byte_data <= shreg;
      // typematic repeats of an already held key produce no pulse
      press <= byte_valid && is_final && !brk ? hit & ~held : '0;
      if (byte_valid) begin
        ext <= byte_data == 8'hE0 || (ext && byte_data == 8'hF0);
        brk <= byte_data == 8'hF0 || (brk && byte_data == 8'hE0);
        if (is_final) {start_key, direction} <= brk ? held & ~hit : held | hit;
      end
    end
  end
  assign bus.direction = direction;
  assign bus.start_key = start_key;
  assign bus.press = press;
  assign bus.byte_valid = byte_valid;
  assign bus.byte_data = byte_data;
  assign bus.frame_err = frame_err;
endmodule
